cpr_fifo: RTL and testbench



---
 rtl/cpr_pkg.sv | 7 +
 rtl/cpr_mem.sv | 44 ++++
 rtl/cpr_fifo.sv | 96 +++++++++
 tb/tb_cpr_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpr_pkg.sv
// Shared defaults for the pair-write / single-read circular FIFO.
package cpr_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 8;

endpackage

// File: rtl/cpr_mem.sv
// DEPTH x WIDTH register array: two write ports at addr and addr+1, one registered read port.
module cpr_mem
    import cpr_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata0,
    input  logic [WIDTH-1:0] i_wdata1,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [AW-1:0]    w_waddr1;

    // Second word wraps modulo DEPTH through the natural pointer width.
    assign w_waddr1 = i_waddr + AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata0;
            r_mem[w_waddr1] <= i_wdata1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpr_fifo.sv
// Circular FIFO accepting a word pair per write and returning one word per read.
module cpr_fifo
    import cpr_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [WIDTH-1:0]           i_wd1,
    input  logic [WIDTH-1:0]           i_wd2,
    input  logic                       i_re,
    output logic [WIDTH-1:0]           o_rd,
    output logic                       o_rd_valid,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthExt = (CW + 1)'(DEPTH);
    localparam logic [CW:0] FullThr  = (CW + 1)'(DEPTH - 2);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_rd_ok;
    logic          w_wr_ok;
    logic [CW:0]   w_count_ext;
    logic [CW:0]   w_free;
    logic [CW:0]   w_count_next;

    // A same-cycle pop frees one slot before pair admission is decided.
    always_comb begin
        w_count_ext  = {1'b0, r_count};
        w_rd_ok      = i_re && (r_count != '0);
        w_free       = DepthExt - w_count_ext + {{CW{1'b0}}, w_rd_ok};
        w_wr_ok      = i_we && (w_free >= (CW + 1)'(2));
        w_count_next = w_count_ext + {{(CW - 1){1'b0}}, w_wr_ok, 1'b0}
                       - {{CW{1'b0}}, w_rd_ok};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(2);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_next[CW-1:0];
            r_rd_valid  <= w_rd_ok;
            r_overflow  <= i_we && !w_wr_ok;
            r_underflow <= i_re && !w_rd_ok;
        end
    end

    cpr_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata0(i_wd1),
        .i_wdata1(i_wd2),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_rd)
    );

    assign o_rd_valid  = r_rd_valid;
    assign o_empty     = (r_count == '0);
    assign o_full      = ({1'b0, r_count} > FullThr);
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_cpr_fifo.sv
// Directed bench for cpr_fifo at WIDTH=16, DEPTH=8.
module tb_cpr_fifo;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] wd1;
    logic [15:0] wd2;
    logic        re;
    logic [15:0] rd;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    cpr_fifo #(
        .WIDTH(16),
        .DEPTH(8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_we       (we),
        .i_wd1      (wd1),
        .i_wd2      (wd2),
        .i_re       (re),
        .o_rd       (rd),
        .o_rd_valid (rd_valid),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count),
        .o_overflow (overflow),
        .o_underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] b, input logic rr);
        rst = r;
        we  = w;
        wd1 = a;
        wd2 = b;
        re  = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wd1 = '0; wd2 = '0; re = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // Single pair, then two pops.
        cyc(0, 1, 16'hAAAA, 16'h5555, 0);
        chk("pair_count", 32'(count), 2);
        chk("pair_empty", 32'(empty), 0);
        cyc(0, 0, 0, 0, 1);
        chk("pop1_rd", 32'(rd), 32'hAAAA);
        chk("pop1_valid", 32'(rd_valid), 1);
        chk("pop1_count", 32'(count), 1);
        cyc(0, 0, 0, 0, 1);
        chk("pop2_rd", 32'(rd), 32'h5555);
        chk("pop2_valid", 32'(rd_valid), 1);
        chk("pop2_empty", 32'(empty), 1);
        cyc(0, 0, 0, 0, 0);
        chk("idle_valid", 32'(rd_valid), 0);
        chk("idle_rd_hold", 32'(rd), 32'h5555);

        // Read on empty.
        cyc(0, 0, 0, 0, 1);
        chk("unf_pulse", 32'(underflow), 1);
        chk("unf_valid", 32'(rd_valid), 0);
        chk("unf_rd_hold", 32'(rd), 32'h5555);
        chk("unf_count", 32'(count), 0);
        cyc(0, 0, 0, 0, 0);
        chk("unf_clear", 32'(underflow), 0);

        // Fill to DEPTH, then one rejected pair.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 16'h1000 + 16'(2 * i), 16'h1001 + 16'(2 * i), 0);
            chk("fill_count", 32'(count), 32'(2 * i + 2));
        end
        chk("fill_full", 32'(full), 1);
        cyc(0, 1, 16'hDEAD, 16'hBEEF, 0);
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_clear", 32'(overflow), 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk("drain_rd", 32'(rd), 32'h1000 + 32'(k));
            chk("drain_valid", 32'(rd_valid), 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_full", 32'(full), 0);

        // Wrap test from zeroed pointers.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'h2000 + 16'(2 * i), 16'h2001 + 16'(2 * i), 0);
        end
        chk("wrap_count6", 32'(count), 6);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk("wrap_rd_a", 32'(rd), 32'h2000 + 32'(k));
        end
        chk("wrap_count1", 32'(count), 1);
        cyc(0, 1, 16'h2006, 16'h2007, 0);
        cyc(0, 1, 16'h2008, 16'h2009, 0);
        chk("wrap_count5", 32'(count), 5);
        for (int k = 5; k < 10; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk("wrap_rd_b", 32'(rd), 32'h2000 + 32'(k));
        end
        chk("wrap_count0", 32'(count), 0);

        // count=7 plus simultaneous write and read.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 16'h3000 + 16'(2 * i), 16'h3001 + 16'(2 * i), 0);
        end
        cyc(0, 0, 0, 0, 1);
        chk("c7_rd", 32'(rd), 32'h3000);
        chk("c7_count", 32'(count), 7);
        chk("c7_full", 32'(full), 1);
        cyc(0, 1, 16'h1111, 16'h2222, 1);
        chk("c7_wr_count", 32'(count), 8);
        chk("c7_wr_ovf", 32'(overflow), 0);
        chk("c7_wr_rd", 32'(rd), 32'h3001);
        chk("c7_wr_valid", 32'(rd_valid), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk("c7_drain_rd", 32'(rd), 32'h3002 + 32'(k));
        end
        chk("c7_count4", 32'(count), 4);

        // Reset with we/re high dominates.
        cyc(1, 1, 16'h7777, 16'h8888, 1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_rd", 32'(rd), 0);

        // Write and read together on empty: read underflows, pair lands.
        cyc(0, 1, 16'h4444, 16'h5A5A, 1);
        chk("we_re_empty_unf", 32'(underflow), 1);
        chk("we_re_empty_count", 32'(count), 2);
        chk("we_re_empty_valid", 32'(rd_valid), 0);
        chk("we_re_empty_rd", 32'(rd), 0);
        cyc(0, 0, 0, 0, 1);
        chk("we_re_pop1", 32'(rd), 32'h4444);
        cyc(0, 0, 0, 0, 1);
        chk("we_re_pop2", 32'(rd), 32'h5A5A);
        chk("we_re_end_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
